memory_io_bus: RTL and testbench
================================

// Module: memory_io_bus
// PURPOSE
//  Data-side slave of processor_staged: consumes memory_addr/memory_write_enable/memory_in,
//  returns memory_out one cycle later. Decodes a RAM region and a small I/O region:
//  an output FIFO to a host (valid/ready) and a single-word input mailbox from the host.
//  Lets programs exchange data with the host between wait/continue points.
// PARAMETERS
//  ADDR_SIZE      18  width of memory_addr
//  WORD_SIZE      18  data word width
//  RAM_ADDR_BITS  10  RAM depth = 2**RAM_ADDR_BITS words
//  FIFO_DEPTH      8  output FIFO entries, power of two, >=2
// PORTS
//  clock                clock   in   1          single clock
//  reset                reset   in   1          synchronous, active-high
//  memory_write_enable  in   1          core write strobe
//  memory_addr          in   ADDR_SIZE  core address
//  memory_in            in   WORD_SIZE  core write data
//  memory_out           out  WORD_SIZE  read data, registered
//  out_data             out  WORD_SIZE  FIFO head word to host
//  out_valid            out  1          FIFO non-empty
//  out_ready            in   1          host accepts head when out_valid
//  in_data              in   WORD_SIZE  host word to mailbox
//  in_valid             in   1          host offers word
//  in_ready             out  1          mailbox empty
// BEHAVIOUR
//  - One clock (clock); reset synchronous active-high. Outputs after reset: memory_out=0,
//    out_valid=0, out_data=0, in_ready=1; FIFO empty, mailbox empty, overflow=0. RAM not cleared.
//  - Decode: addr[ADDR_SIZE-1]==0 -> RAM, index addr[RAM_ADDR_BITS-1:0] (upper bits ignored, alias).
//    addr[ADDR_SIZE-1]==1 -> I/O, offset addr[3:0]; offsets >=4 (or 3 without timer) read 0, writes ignored.
//  - Read latency exactly 1: memory_out at cycle N+1 reflects addr at cycle N; RAM write at N
//    to same addr, read at N+1, returns new data. No stalls, no wait states.
//  - I/O offset 0 OUT: write pushes memory_in; read returns FIFO count (zero-extended).
//  - I/O offset 1 STATUS: read {.., bit3 in_full, bit2 overflow, bit1 fifo_full, bit0 fifo_empty};
//    write with memory_in[2]==1 clears overflow.
//  - I/O offset 2 IN: read returns mailbox word and empties mailbox (pop on read); read when
//    empty returns 0, no effect. Writes ignored.
//  - FIFO: handshake transfer when out_valid&&out_ready. Push accepted if not full, or full
//    with same-cycle pop (count unchanged). Push to full FIFO without pop: word dropped,
//    overflow set (sticky). Pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
//  - Mailbox: host transfer when in_valid&&in_ready; in_ready=!in_full. Core pop and host
//    write in same cycle impossible (in_ready low while full); new word visible to core next cycle.
//  - out_data/out_valid/in_ready derived from registered state only (no comb path from ready/valid).
//  - Reset mid-operation: FIFO/mailbox contents discarded, pending read data -> 0.
// CONFIGURATION
//  - MEMORY_IO_TIMER_EN defined: I/O offset 3 TIMER = free-running WORD_SIZE counter, +1 per
//    clock, wraps to 0, reset 0; write loads memory_in (load wins over increment).
//  - Undefined: no counter logic; offset 3 reads 0, writes ignored.
// STRUCTURE
//  - Package memory_io_pkg: IO offset constants (IO_OUT=0, IO_STATUS=1, IO_IN=2, IO_TIMER=3),
//    STATUS bit positions, io region select bit.
//  - Sub-module sync_fifo (WIDTH, DEPTH): push/pop/full/empty/count, same-cycle push+pop at full.
//  - RAM as inferred synchronous array inside memory_io_bus; registered read-mux select.
// TESTING
//  - RAM: write 0x12345 @0x00005, read @0x00005 next cycle -> memory_out=0x12345 one cycle after.
//  - FIFO order: out_ready=0, push 0x1,0x2,0x3 -> count read=3; out_ready=1 -> 0x1,0x2,0x3 then out_valid=0.
//  - Overflow: depth 8, push 9 words, out_ready=0 -> STATUS=0b0110, 9th dropped; write 0x4 -> bit2 clears.
//  - Full+pop: FIFO full, out_ready=1 and push 0xAA same cycle -> count stays 8, overflow=0, 0xAA last out.
//  - Mailbox: host in_valid 0x3FFFF -> in_ready=0, STATUS bit3=1; read IN -> 0x3FFFF, next in_ready=1; reread -> 0.
//  - Timer (EN): write 0x3FFFE @offset 3, read two cycles later -> 0x00000 (wrap); reset mid-FIFO -> out_valid=0.

Source files
------------

// File: rtl/memory_io_pkg.sv
// memory_io_pkg: shared constants for the memory_io_bus data-side slave.
//   - I/O register offsets within the I/O region (address bits [3:0])
//   - bit positions inside the STATUS register
//   - helper that names the address bit selecting the I/O region
//   - read-data source select for the registered read mux
package memory_io_pkg;

  localparam int IO_OFFSET_W = 4;

  localparam logic [IO_OFFSET_W-1:0] IO_OUT    = 4'd0;
  localparam logic [IO_OFFSET_W-1:0] IO_STATUS = 4'd1;
  localparam logic [IO_OFFSET_W-1:0] IO_IN     = 4'd2;
  localparam logic [IO_OFFSET_W-1:0] IO_TIMER  = 4'd3;

  localparam int ST_FIFO_EMPTY = 0;
  localparam int ST_FIFO_FULL  = 1;
  localparam int ST_OVERFLOW   = 2;
  localparam int ST_IN_FULL    = 3;

  // The top address bit splits RAM (0) from I/O (1).
  function automatic int io_sel_bit(input int addr_size);
    return addr_size - 1;
  endfunction

  typedef enum logic {
    RD_RAM = 1'b0,
    RD_IO  = 1'b1
  } rd_src_e;

endpackage

// File: rtl/memory_io_bus_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and occupancy count.
//   clock, reset : clock, synchronous active-high reset (pointers/count only)
//   push, wdata  : write request and data; accepted when not full, or when
//                  full with a same-cycle pop
//   pop          : read request; ignored while empty
//   rdata        : head word (undefined content while empty)
//   full, empty  : occupancy flags; count : 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/memory_io_bus.sv
// memory_io_bus: data-side slave for processor_staged. RAM region plus a small
// I/O region (output FIFO to host, single-word input mailbox, optional timer).
// Read data appears on memory_out exactly one cycle after the address.
// Optional feature: define MEMORY_IO_TIMER_EN to add the free-running timer at
// I/O offset 3; without it offset 3 reads 0 and ignores writes.
// Ports:
//   clock, reset         single clock, synchronous active-high reset
//   memory_write_enable  core write strobe
//   memory_addr          core address (MSB selects I/O region)
//   memory_in            core write data
//   memory_out           read data, one cycle after address
//   out_data, out_valid  FIFO head word / FIFO non-empty (to host)
//   out_ready            host accepts head word
//   in_data, in_valid    host word offered to mailbox
//   in_ready             mailbox empty
module memory_io_bus
  import memory_io_pkg::*;
#(
  parameter int ADDR_SIZE     = 18,
  parameter int WORD_SIZE     = 18,
  parameter int RAM_ADDR_BITS = 10,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 memory_write_enable,
  input  logic [ADDR_SIZE-1:0] memory_addr,
  input  logic [WORD_SIZE-1:0] memory_in,
  output logic [WORD_SIZE-1:0] memory_out,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                     is_io;
  logic [IO_OFFSET_W-1:0]   io_off;
  logic [RAM_ADDR_BITS-1:0] ram_idx;
  logic                     ram_we;
  logic                     wr_out;
  logic                     wr_status;
  logic                     rd_in;
  logic                     unused_addr;

  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  logic [WORD_SIZE-1:0]     fifo_head;

  logic                     overflow;
  logic                     in_full;
  logic [WORD_SIZE-1:0]     mbox_data;

  logic [WORD_SIZE-1:0]     ram [2**RAM_ADDR_BITS];
  logic [WORD_SIZE-1:0]     status_word;
  logic [WORD_SIZE-1:0]     io_rdata;

  logic [WORD_SIZE-1:0]     ram_rdata_p0;
  logic [WORD_SIZE-1:0]     io_rdata_p0;
  rd_src_e                  rd_src_p0;

  assign is_io       = memory_addr[io_sel_bit(ADDR_SIZE)];
  assign io_off      = memory_addr[IO_OFFSET_W-1:0];
  assign ram_idx     = memory_addr[RAM_ADDR_BITS-1:0];
  // Bits between the RAM index and the region bit only alias the RAM.
  assign unused_addr = ^memory_addr[ADDR_SIZE-2:RAM_ADDR_BITS];

  assign ram_we    = memory_write_enable && !is_io;
  assign wr_out    = memory_write_enable && is_io && (io_off == IO_OUT);
  assign wr_status = memory_write_enable && is_io && (io_off == IO_STATUS);
  assign rd_in     = !memory_write_enable && is_io && (io_off == IO_IN);

  assign fifo_pop  = !fifo_empty && out_ready;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_head;
  assign in_ready  = !in_full;

  sync_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wr_out),
    .pop   (fifo_pop),
    .wdata (memory_in),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky until software writes STATUS with the overflow bit set.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_out && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end else if (wr_status && memory_in[ST_OVERFLOW]) begin
      overflow <= 1'b0;
    end
  end

  // Host fill and core pop never coincide: in_ready is low while full.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_full <= 1'b0;
    end else if (in_valid && !in_full) begin
      in_full <= 1'b1;
    end else if (rd_in && in_full) begin
      in_full <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (in_valid && !in_full) mbox_data <= in_data;
  end

`ifdef MEMORY_IO_TIMER_EN
  logic [WORD_SIZE-1:0] timer;

  always_ff @(posedge clock) begin
    if (reset) begin
      timer <= '0;
    end else if (memory_write_enable && is_io && (io_off == IO_TIMER)) begin
      timer <= memory_in;
    end else begin
      timer <= timer + WORD_SIZE'(1);
    end
  end
`endif

  always_comb begin
    status_word                = '0;
    status_word[ST_FIFO_EMPTY] = fifo_empty;
    status_word[ST_FIFO_FULL]  = fifo_full;
    status_word[ST_OVERFLOW]   = overflow;
    status_word[ST_IN_FULL]    = in_full;
  end

  always_comb begin
    io_rdata = '0;
    case (io_off)
      IO_OUT:    io_rdata = WORD_SIZE'(fifo_count);
      IO_STATUS: io_rdata = status_word;
      IO_IN:     io_rdata = in_full ? mbox_data : '0;
`ifdef MEMORY_IO_TIMER_EN
      IO_TIMER:  io_rdata = timer;
`endif
      default:   io_rdata = '0;
    endcase
  end

  // ---- stage p0: registered RAM read, I/O read data and mux select ----
  // A write in the same cycle forwards the new word (write-first).
  always_ff @(posedge clock) begin
    if (ram_we) ram[ram_idx] <= memory_in;
    ram_rdata_p0 <= ram_we ? memory_in : ram[ram_idx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_src_p0   <= RD_IO;
      io_rdata_p0 <= '0;
    end else begin
      rd_src_p0   <= is_io ? RD_IO : RD_RAM;
      io_rdata_p0 <= io_rdata;
    end
  end

  assign memory_out = (rd_src_p0 == RD_RAM) ? ram_rdata_p0 : io_rdata_p0;

endmodule

// File: tb/tb_memory_io_bus.sv
// tb_memory_io_bus: directed bench for memory_io_bus with a queue-based
// reference model checked every cycle, plus hand-computed literal checks.
module tb_memory_io_bus;

  localparam int AW = 18;
  localparam int WW = 18;
  localparam int FD = 8;
  localparam logic [AW-1:0] IO   = 18'h20000;
  localparam logic [AW-1:0] IDLE = 18'h20007;
`ifdef MEMORY_IO_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          memory_write_enable;
  logic [AW-1:0] memory_addr;
  logic [WW-1:0] memory_in;
  logic [WW-1:0] memory_out;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;

  memory_io_bus dut (
    .clock               (clock),
    .reset               (reset),
    .memory_write_enable (memory_write_enable),
    .memory_addr         (memory_addr),
    .memory_in           (memory_in),
    .memory_out          (memory_out),
    .out_data            (out_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .in_data             (in_data),
    .in_valid            (in_valid),
    .in_ready            (in_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
  endtask

  // Reference model: RAM array, FIFO as a queue, mailbox flag/word, timer.
  logic [WW-1:0] ram_m [1024];
  bit            ram_known [1024];
  logic [WW-1:0] q [$];
  bit            ovf_m, mb_full_m, model_live, exp_known;
  logic [WW-1:0] mb_m, timer_m, exp_out;
  int            idx;
  bit            host_take, io_acc;
  logic [3:0]    off;

  initial begin
    model_live = 1'b0;
    for (int i = 0; i < 1024; i++) ram_known[i] = 1'b0;
  end

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      ovf_m = 0; mb_full_m = 0; timer_m = '0; exp_out = '0;
      exp_known = 1; model_live = 1;
    end else if (model_live) begin
      idx       = int'(memory_addr[9:0]);
      off       = memory_addr[3:0];
      io_acc    = memory_addr[AW-1];
      host_take = in_valid && !mb_full_m;
      exp_known = 1;
      if (!io_acc) begin
        if (memory_write_enable) begin
          exp_out = memory_in;
          ram_m[idx] = memory_in;
          ram_known[idx] = 1;
        end else begin
          exp_out   = ram_m[idx];
          exp_known = ram_known[idx];
        end
      end else begin
        case (off)
          4'd0:    exp_out = WW'(q.size());
          4'd1:    exp_out = {14'b0, mb_full_m, ovf_m, q.size() == FD, q.size() == 0};
          4'd2:    exp_out = mb_full_m ? mb_m : '0;
          4'd3:    exp_out = TIMER_EN ? timer_m : '0;
          default: exp_out = '0;
        endcase
      end
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (io_acc && memory_write_enable && off == 4'd0) begin
        if (q.size() < FD) q.push_back(memory_in);
        else ovf_m = 1;
      end
      if (io_acc && memory_write_enable && off == 4'd1 && memory_in[2]) ovf_m = 0;
      if (io_acc && !memory_write_enable && off == 4'd2) mb_full_m = 0;
      if (host_take) begin
        mb_full_m = 1;
        mb_m = in_data;
      end
      if (io_acc && memory_write_enable && off == 4'd3) timer_m = memory_in;
      else timer_m = timer_m + 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (model_live) begin
      if (exp_known) chk("memory_out", memory_out, exp_out);
      chk1("out_valid", out_valid, q.size() > 0);
      chk("out_data", out_data, (q.size() > 0) ? q[0] : '0);
      chk1("in_ready", in_ready, !mb_full_m);
    end
  end

  task automatic cyc(input logic we, input logic [AW-1:0] a, input logic [WW-1:0] d);
    @(posedge clock);
    #1;
    memory_write_enable = we;
    memory_addr = a;
    memory_in = d;
  endtask

  task automatic read_bus(input logic [AW-1:0] a, output logic [WW-1:0] v);
    cyc(1'b0, a, '0);
    cyc(1'b0, IDLE, '0);
    @(negedge clock);
    v = memory_out;
  endtask

  logic [WW-1:0] v;

  initial begin
    reset = 1'b1;
    memory_write_enable = 1'b0;
    memory_addr = IDLE;
    memory_in = '0;
    out_ready = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("rst memory_out", memory_out, 18'h0);
    chk1("rst out_valid", out_valid, 1'b0);
    chk("rst out_data", out_data, 18'h0);
    chk1("rst in_ready", in_ready, 1'b1);
    @(posedge clock);
    #1 reset = 1'b0;

    // RAM write then read, and alias through ignored upper address bits
    cyc(1'b1, 18'h00005, 18'h12345);
    read_bus(18'h00005, v);
    chk("ram read", v, 18'h12345);
    read_bus(18'h00405, v);
    chk("ram alias", v, 18'h12345);

    // FIFO ordering
    cyc(1'b1, IO, 18'h1);
    cyc(1'b1, IO, 18'h2);
    cyc(1'b1, IO, 18'h3);
    read_bus(IO, v);
    chk("fifo count 3", v, 18'd3);
    for (int i = 1; i <= 3; i++) begin
      chk("fifo order", out_data, WW'(i));
      if (i == 1) out_ready = 1'b1;
      @(negedge clock);
    end
    chk1("fifo drained", out_valid, 1'b0);
    out_ready = 1'b0;

    // Overflow: nine pushes into depth eight
    for (int i = 0; i < 9; i++) cyc(1'b1, IO, WW'(18'h10 + i));
    read_bus(IO + 18'd1, v);
    chk("status overflow", v, 18'b0110);
    cyc(1'b1, IO + 18'd1, 18'h4);
    read_bus(IO + 18'd1, v);
    chk("status cleared", v, 18'b0010);

    // Full FIFO with push and pop in the same cycle
    cyc(1'b1, IO, 18'hAA);
    out_ready = 1'b1;
    cyc(1'b0, IDLE, '0);
    out_ready = 1'b0;
    read_bus(IO, v);
    chk("full+pop count", v, 18'd8);
    read_bus(IO + 18'd1, v);
    chk("full+pop status", v, 18'b0010);
    chk("full+pop head", out_data, 18'h11);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = out_data;
      @(negedge clock);
    end
    chk("full+pop last", v, 18'hAA);
    chk1("full+pop drained", out_valid, 1'b0);
    out_ready = 1'b0;

    // Mailbox
    in_valid = 1'b1;
    in_data = 18'h3FFFF;
    cyc(1'b0, IDLE, '0);
    in_valid = 1'b0;
    @(negedge clock);
    chk1("mbox in_ready low", in_ready, 1'b0);
    read_bus(IO + 18'd1, v);
    chk("mbox status", v, 18'b1001);
    read_bus(IO + 18'd2, v);
    chk("mbox read", v, 18'h3FFFF);
    chk1("mbox in_ready high", in_ready, 1'b1);
    read_bus(IO + 18'd2, v);
    chk("mbox reread", v, 18'h0);

    // Timer (or absent timer) and unmapped offset
    cyc(1'b1, IO + 18'd3, 18'h3FFFE);
    cyc(1'b0, IDLE, '0);
    cyc(1'b0, IDLE, '0);
    read_bus(IO + 18'd3, v);
    chk("timer wrap", v, 18'h0);
    read_bus(IO + 18'd3, v);
    chk("timer count", v, TIMER_EN ? 18'd2 : 18'd0);
    read_bus(IO + 18'd5, v);
    chk("unmapped offset", v, 18'h0);

    // Reset in the middle of traffic
    cyc(1'b1, IO, 18'h55);
    cyc(1'b1, IO, 18'h66);
    in_valid = 1'b1;
    in_data = 18'h123;
    cyc(1'b0, 18'h00005, '0);
    in_valid = 1'b0;
    reset = 1'b1;
    cyc(1'b0, IDLE, '0);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst memory_out", memory_out, 18'h0);
    chk1("midrst out_valid", out_valid, 1'b0);
    chk("midrst out_data", out_data, 18'h0);
    chk1("midrst in_ready", in_ready, 1'b1);
    read_bus(IO, v);
    chk("midrst count", v, 18'd0);

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
